// File: rtl/equ_4_5_pkg.sv
// Shared widths, constants and FSM state type for the gradient-normalisation stage.
package equ_4_5_pkg;

   localparam int unsigned GRAD_W = 16;
   localparam int unsigned OUT_W  = 8;
   localparam int unsigned SCALE  = (1 << OUT_W) - 1;
   localparam int unsigned ITER   = OUT_W;
   localparam int unsigned CNT_W  = $clog2(ITER);
   localparam int unsigned SUM_W  = GRAD_W + 1;
   localparam int unsigned NUM_W  = GRAD_W + OUT_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : equ_4_5_pkg

// File: rtl/equ_4_5_scale_div.sv
// Restoring divider step unit: resolves one quotient bit per step, MSB first.
//   clk, rst   : clock, async active-low reset
//   load_i     : capture numerator into remainder, clear quotient
//   step_i     : resolve quotient bit k_i
//   k_i        : bit position being resolved this step
//   num_i      : numerator (grad * 255)
//   div_i      : divisor (sum of both gradients)
//   quot_o     : quotient register
module scale_div
   import equ_4_5_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [CNT_W-1:0]  k_i,
   input  logic [NUM_W-1:0]  num_i,
   input  logic [SUM_W-1:0]  div_i,
   output logic [OUT_W-1:0]  quot_o
);

   logic [NUM_W-1:0] rem_q, rem_d;
   logic [OUT_W-1:0] quot_q, quot_d;
   logic [NUM_W-1:0] shifted_c;
   logic             take_c;

   // div<<7 still fits NUM_W since the sum is at most 2^17-2.
   assign shifted_c = NUM_W'(div_i) << k_i;
   // A zero divisor never sets a bit, so 0/0 yields 0.
   assign take_c    = (div_i != '0) && (rem_q >= shifted_c);

   always_comb begin
      rem_d  = rem_q;
      quot_d = quot_q;
      if (load_i) begin
         rem_d  = num_i;
         quot_d = '0;
      end else if (step_i && take_c) begin
         rem_d       = rem_q - shifted_c;
         quot_d[k_i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q  <= '0;
         quot_q <= '0;
      end else begin
         rem_q  <= rem_d;
         quot_q <= quot_d;
      end
   end

   assign quot_o = quot_q;

endmodule : scale_div

// File: rtl/equ_4_5.sv
// Gradient normalisation: scaled = floor(255*grad/(grad_hs+grad_vs)) for both gradients.
//   clk, rst    : clock, async active-low reset
//   strat       : start request, sampled in IDLE
//   grad_hs/vs  : unsigned gradient sums
//   scaled_hs/vs: 8-bit weights, held between results
//   ready       : one-cycle pulse with each new result
module equ_4_5
   import equ_4_5_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              strat,
   input  logic [GRAD_W-1:0] grad_hs,
   input  logic [GRAD_W-1:0] grad_vs,
   output logic [OUT_W-1:0]  scaled_hs,
   output logic [OUT_W-1:0]  scaled_vs,
   output logic              ready
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic [OUT_W-1:0]   scaled_hs_q, scaled_hs_d;
   logic [OUT_W-1:0]   scaled_vs_q, scaled_vs_d;
   logic               ready_q, ready_d;
   logic               load_c, step_c;
   logic [CNT_W-1:0]   k_c;
   logic [NUM_W-1:0]   num_hs_c, num_vs_c;
   logic [OUT_W-1:0]   quot_hs_c, quot_vs_c;

   // Counter runs up; bit index runs down from MSB.
   assign k_c      = CNT_W'(ITER - 1) - cnt_q;
   assign num_hs_c = NUM_W'(grad_hs) * NUM_W'(SCALE);
   assign num_vs_c = NUM_W'(grad_vs) * NUM_W'(SCALE);

   // Next-state and control.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      scaled_hs_d = scaled_hs_q;
      scaled_vs_d = scaled_vs_q;
      ready_d     = 1'b0;
      load_c      = 1'b0;
      step_c      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (strat) begin
               load_c  = 1'b1;
               sum_d   = SUM_W'(grad_hs) + SUM_W'(grad_vs);
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            step_c = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITER - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            scaled_hs_d = quot_hs_c;
            scaled_vs_d = quot_vs_c;
            ready_d     = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sum_q       <= '0;
         scaled_hs_q <= '0;
         scaled_vs_q <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         scaled_hs_q <= scaled_hs_d;
         scaled_vs_q <= scaled_vs_d;
         ready_q     <= ready_d;
      end
   end

   scale_div u_div_hs (
      .clk    (clk),
      .rst    (rst),
      .load_i (load_c),
      .step_i (step_c),
      .k_i    (k_c),
      .num_i  (num_hs_c),
      .div_i  (sum_q),
      .quot_o (quot_hs_c)
   );

   scale_div u_div_vs (
      .clk    (clk),
      .rst    (rst),
      .load_i (load_c),
      .step_i (step_c),
      .k_i    (k_c),
      .num_i  (num_vs_c),
      .div_i  (sum_q),
      .quot_o (quot_vs_c)
   );

   assign scaled_hs = scaled_hs_q;
   assign scaled_vs = scaled_vs_q;
   assign ready     = ready_q;

endmodule : equ_4_5

// File: tb/tb_equ_4_5.sv
// Directed scoreboard bench for equ_4_5.
module tb_equ_4_5;

   logic        clk;
   logic        rst;
   logic        strat;
   logic [15:0] grad_hs;
   logic [15:0] grad_vs;
   logic [7:0]  scaled_hs;
   logic [7:0]  scaled_vs;
   logic        ready;

   int checks   = 0;
   int failures = 0;
   logic [15:0] exp_q[$];

   equ_4_5 dut (
      .clk       (clk),
      .rst       (rst),
      .strat     (strat),
      .grad_hs   (grad_hs),
      .grad_vs   (grad_vs),
      .scaled_hs (scaled_hs),
      .scaled_vs (scaled_vs),
      .ready     (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [15:0] h, input logic [15:0] v);
      longint unsigned s, eh, ev;
      s = longint'(h) + longint'(v);
      if (s == 0) return 16'h0000;
      eh = (255 * longint'(h)) / s;
      ev = (255 * longint'(v)) / s;
      return {8'(eh), 8'(ev)};
   endfunction

   // One computation; optional strat re-pulse at cycle repulse (0 = none).
   task automatic run_op(input string tag, input logic [15:0] h, input logic [15:0] v,
                         input int repulse);
      int          seen;
      int          n_ready;
      logic [7:0]  obs_hs, obs_vs;
      logic [15:0] e;
      exp_q.push_back(model(h, v));
      @(negedge clk);
      grad_hs = h; grad_vs = v; strat = 1'b1;
      @(posedge clk); #1;
      strat = 1'b0;
      grad_hs = 16'($urandom); grad_vs = 16'($urandom);
      seen = -1; n_ready = 0; obs_hs = '0; obs_vs = '0;
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk); #1;
         if (repulse != 0 && c == repulse)     strat = 1'b1;
         if (repulse != 0 && c == repulse + 1) strat = 1'b0;
         if (ready) begin
            n_ready++;
            if (seen < 0) begin
               seen = c; obs_hs = scaled_hs; obs_vs = scaled_vs;
            end
         end
      end
      chk({tag, "_latency"}, seen, 9);
      chk({tag, "_pulses"}, n_ready, 1);
      e = exp_q.pop_front();
      chk({tag, "_hs"}, obs_hs, e[15:8]);
      chk({tag, "_vs"}, obs_vs, e[7:0]);
      chk({tag, "_hold_hs"}, scaled_hs, e[15:8]);
      chk({tag, "_hold_vs"}, scaled_vs, e[7:0]);
   endtask

   initial begin
      int n_ready;
      logic [15:0] rh, rv;
      rst = 1'b0; strat = 1'b0; grad_hs = '0; grad_vs = '0;
      #100;
      chk("reset_hs", scaled_hs, 0);
      chk("reset_vs", scaled_vs, 0);
      chk("reset_ready", ready, 0);
      @(negedge clk); rst = 1'b1;
      n_ready = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (ready) n_ready++;
      end
      chk("idle_no_ready", n_ready, 0);
      chk("idle_hs", scaled_hs, 0);

      run_op("one_zero", 16'd1, 16'd0, 0);
      run_op("equal150", 16'd150, 16'd150, 0);
      run_op("h3000_v4500", 16'd3000, 16'd4500, 0);
      run_op("max_max", 16'd65535, 16'd65535, 0);
      run_op("zero_zero", 16'd0, 16'd0, 0);
      run_op("zero_one", 16'd0, 16'd7, 0);
      run_op("repulse", 16'd1000, 16'd3, 3);

      // Abort mid-CALC with reset.
      @(negedge clk);
      grad_hs = 16'd500; grad_vs = 16'd100; strat = 1'b1;
      @(posedge clk); #1;
      strat = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("abort_hs", scaled_hs, 0);
      chk("abort_vs", scaled_vs, 0);
      chk("abort_ready", ready, 0);
      @(negedge clk); rst = 1'b1;
      n_ready = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (ready) n_ready++;
      end
      chk("abort_no_ready", n_ready, 0);

      run_op("after_abort", 16'd3000, 16'd4500, 0);
      for (int i = 0; i < 3; i++) begin
         rh = 16'($urandom); rv = 16'($urandom);
         run_op($sformatf("rand%0d", i), rh, rv, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_equ_4_5

// File: doc/equ_4_5.md
Name: equ_4_5

Overview:
- Gradient-normalisation stage of the CFA demosaicing pipeline. It implements equations 4 and 5.
- It takes the horizontal and vertical gradient sums from the convolution stage. It produces two 8-bit weights, each equal to that gradient's share of the total, scaled to 0..255.
- It is a sequential, start/ready handshaked block. Two shared-structure restoring dividers run in parallel.

Parameters:
- GRAD_W, 16, width of each gradient input.
- OUT_W, 8, width of each scaled output. SCALE = 2^OUT_W - 1 = 255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- strat  in  1  start request, sampled high while idle.
- grad_hs  in  GRAD_W  horizontal gradient, unsigned.
- grad_vs  in  GRAD_W  vertical gradient, unsigned.
- scaled_hs  out  OUT_W  floor(255*grad_hs/(grad_hs+grad_vs)).
- scaled_vs  out  OUT_W  floor(255*grad_vs/(grad_hs+grad_vs)).
- ready  out  1  one-cycle pulse marking new valid outputs.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - scaled_hs=0, scaled_vs=0, ready=0.
  - All internal registers cleared.
  - Reset asserted mid-computation aborts the computation; no ready pulse is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - On a clk edge with strat=1, latch grad_hs/grad_vs.
  - Compute S = grad_hs + grad_vs (GRAD_W+1 bits, no overflow).
  - Compute numerators Nh = grad_hs*255 and Nv = grad_vs*255 (GRAD_W+8 bits).
  - Clear the iteration counter, then go to CALC.
- CALC:
  - 8 cycles. Cycle k (k=7..0) resolves quotient bit k of both quotients in parallel.
  - Bit rule: if remainder >= (S<<k), subtract and set bit=1; else bit=0.
  - Because N <= 255*S, each quotient fits in 8 bits, so no saturation is needed.
  - After the 8th cycle, go to DONE.
- DONE:
  - Exactly one cycle.
  - scaled_hs and scaled_vs are loaded with the quotients, and ready=1 for this cycle only. Then go to IDLE.
- Latency: strat sampled at edge E0 gives ready high and outputs updated after edge E0+9. Throughput is one result per 10 cycles; with strat held high, a new computation starts on the edge after DONE.
- Outputs hold their last value between ready pulses. ready is 0 except in DONE.
- strat is ignored in CALC and DONE. Inputs may change freely after E0 because they are latched.
- S == 0 (both gradients zero): the divide is skipped. Both outputs are 0, with the same 10-cycle timing and the ready pulse.
- Rounding is truncation. scaled_hs + scaled_vs is 254 or 255 when S > 0.
- All arithmetic is unsigned.

Decomposition:
- Shared package:
  - GRAD_W=16, OUT_W=8, SCALE=255, ITER=8.
  - State enum {IDLE, CALC, DONE}.
  - Widths SUM_W = GRAD_W+1 and NUM_W = GRAD_W+8.
- One natural sub-module, scale_div: an 8-iteration restoring divider step unit.
  - Holds the remainder and quotient registers.
  - Inputs: numerator, divisor, load, step.
  - Output: 8-bit quotient.
  - Instantiated twice, for hs and vs. The top holds the FSM and counter.

Test Plan:
- rst=0 for 100 ns then release; strat=0 -> outputs 0, ready never asserts.
- grad_hs=1, grad_vs=0, strat pulse -> 10 cycles later ready=1 for one cycle, scaled_hs=255, scaled_vs=0.
- grad_hs=150, grad_vs=150 -> scaled_hs=127, scaled_vs=127.
- grad_hs=3000, grad_vs=4500 -> scaled_hs=102, scaled_vs=153. Also grad_hs=65535, grad_vs=65535 -> 127/127 (no overflow).
- grad_hs=0, grad_vs=0 -> ready after 10 cycles, outputs 0/0.
- strat re-pulsed during CALC -> ignored, single ready. rst pulled low mid-CALC -> outputs 0, no ready, the next start works normally.
